// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : MEM-stage data memory with RV32I sub-word access and fixed latency
// Revision : 1.0
// ============================================================================
module dmem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        op_write;
   logic [31:0] op_addr;
   logic [2:0]  op_funct3;
   logic [31:0] op_wdata;

   logic [31:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic [31:0]           rd_word;
   logic [31:0]           rd_shift;
   logic [15:0]           rd_half;
   logic [31:0]           load_data;
   logic [31:0]           wr_mask;
   logic [31:0]           wr_data;
   logic [31:0]           wr_word;
   logic                  legal;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  acc_err;
   logic                  do_access;

   assign word_idx  = op_addr[ADDR_WIDTH+1:2];
   assign lane      = op_addr[1:0];
   assign rd_word   = mem[word_idx];
   assign rd_shift  = rd_word >> {lane, 3'b000};
   assign rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
   assign do_access = (state == S_WAIT) && (cnt == 4'd0);

   always_comb begin
      legal        = 1'b0;
      misaligned   = 1'b0;
      load_data    = 32'd0;
      wr_mask      = 32'd0;
      wr_data      = 32'd0;
      out_of_range = (op_addr >> (ADDR_WIDTH + 2)) != 32'd0;

      if (op_write) begin
         legal = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) ||
                 (op_funct3 == 3'b010);
      end else begin
         legal = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) ||
                 (op_funct3 == 3'b010) || (op_funct3 == 3'b100) ||
                 (op_funct3 == 3'b101);
      end

      // funct3[1:0] encodes the access size for both loads and stores
      case (op_funct3[1:0])
         2'b00: begin
            wr_mask = 32'h0000_00FF << {lane, 3'b000};
            wr_data = {24'd0, op_wdata[7:0]} << {lane, 3'b000};
            load_data = op_funct3[2] ? {24'd0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
         end
         2'b01: begin
            misaligned = lane[0];
            wr_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wr_data = lane[1] ? {op_wdata[15:0], 16'd0} : {16'd0, op_wdata[15:0]};
            load_data = op_funct3[2] ? {16'd0, rd_half}
                                     : {{16{rd_half[15]}}, rd_half};
         end
         2'b10: begin
            misaligned = (lane != 2'b00);
            wr_mask    = 32'hFFFF_FFFF;
            wr_data    = op_wdata;
            load_data  = rd_word;
         end
         default: begin
            misaligned = 1'b0;
         end
      endcase
   end

   assign acc_err = !legal || misaligned || out_of_range;
   assign wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);

   // Array is deliberately not reset; reset on the access edge suppresses the write
   always_ff @(posedge clk) begin
      if (!reset && do_access && op_write && !acc_err) begin
         mem[word_idx] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         op_write   <= 1'b0;
         op_addr    <= 32'd0;
         op_funct3  <= 3'd0;
         op_wdata   <= 32'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_RESP: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  op_write  <= req_write;
                  op_addr   <= req_addr;
                  op_funct3 <= req_funct3;
                  op_wdata  <= req_wdata;
                  cnt       <= CNT_INIT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_WAIT;
               end else begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_rdata <= (op_write || acc_err) ? 32'd0 : load_data;
                  resp_err   <= acc_err;
                  resp_valid <= 1'b1;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_RESP;
               end
            end
            default: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's MEM-stage data accesses. Accepts one load or store request at a time over a valid/ready handshake and performs the RV32I sub-word access (byte/half/word, sign/zero extension) on an internal word-organised array. Returns the result after a programmable fixed latency, so the pipeline's stall logic can be exercised against a non-ideal memory.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address bits; the array holds 2^ADDR_WIDTH 32-bit words and the byte range is 0 .. 2^(ADDR_WIDTH+2)-1.
- LATENCY, 2, cycles from request acceptance to response; legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high in IDLE and RESP, low in WAIT.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  RV32I load/store funct3.
- req_wdata  in  32  store data; the low byte or half is used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; illegal funct3, misaligned access, or out of range.
- busy  out  1  high while in WAIT; the pipeline stalls on it.

## Operation
- States: IDLE, WAIT and RESP.
  - IDLE: req_ready=1. When req_valid=1, latch write/addr/funct3/wdata, load cnt=LATENCY-1, and go to WAIT.
  - WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access, register the response, and go to RESP.
  - RESP: resp_valid=1 and req_ready=1. If req_valid=1, accept the new request and go to WAIT. Otherwise go to IDLE.
- Responses have no backpressure; the requester must consume resp_valid in the cycle it is high.
- Loads (funct3):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - Any other funct3 is an error.
- Stores (funct3):
  - 000 SB: modify only the addressed byte lane.
  - 001 SH: modify only the addressed half.
  - 010 SW: write the full word.
  - Any other funct3 is an error.
- Byte ordering is little-endian. Word index is addr[ADDR_WIDTH+1:2]. Byte lane is addr[1:0].
- Error conditions:
  - funct3 illegal for the request direction.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:ADDR_WIDTH+2] nonzero.
- On error: no array write, resp_rdata=0, resp_err=1. The response still arrives after LATENCY.
- Stores respond with resp_rdata=0, resp_err=0.
- Array contents are not reset; a read before any write returns undefined data.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- Accept on edge N means the array read/write happens at edge N+LATENCY. resp_valid is high in the cycle after edge N+LATENCY, for exactly one cycle.
- Throughput is one request per LATENCY+1 cycles. Back-to-back acceptance in RESP gives no idle bubble.
- A store accepted at N is visible to a load accepted at or after the store's RESP cycle.
- resp_rdata and resp_err hold their last values after resp_valid falls, until the next access edge.
- Reset mid-operation: the pending request is dropped. No array write occurs if reset is asserted on or before the access edge. No response is issued. Outputs return to reset values on the next edge.
- req_valid while in WAIT is ignored; the requester must hold it until req_ready=1.
- resp_valid and busy are never high in the same cycle.

## Test plan
- SW 0xDEADBEEF at 0x10, then LW 0x10 -> the first resp_valid occurs exactly LATENCY+1 cycles after the store is accepted; load response rdata=0xDEADBEEF, err=0.
- After the above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF. SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- LW 0x11, SH 0x13, address 0x400 (ADDR_WIDTH=8), funct3=011 -> each gives resp_err=1, rdata=0. A following LW 0x10 is unchanged.
- Back-to-back: req_valid held high for 4 requests with LATENCY=3 -> resp_valid pulses every 4 cycles. busy=1 for 3 cycles between pulses.
- SW 0x20 data 0x1 accepted, reset asserted 1 cycle later -> no resp_valid. After reset, SW 0x20 data 0x2 then LW 0x20 -> 0x2.
